// File: rtl/ex_muldiv_unit.sv
// Iterative integer multiply/divide unit for the EX stage; owns HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle, then one FIX
// cycle for sign correction and special cases. Fixed latency WIDTH+2.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Start, Func     operation request and MIPS funct code
//   Rdata1, Rdata2  rs / rt operands
//   Abort           pipeline flush, cancels any in-flight operation
//   Busy, Done      in-flight flag, one-cycle completion pulse
//   HI, LO          architectural HI/LO registers
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] m_q, m_d;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0] raw_q, raw_d;     // dividend as presented, for divide-by-zero
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Operand conditioning at accept time
  logic             op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_sgn = (Func == F_MULT) || (Func == F_DIV);
  assign a_neg  = op_sgn && Rdata1[WIDTH-1];
  assign b_neg  = op_sgn && Rdata2[WIDTH-1];
  assign a_abs  = a_neg ? -Rdata1 : Rdata1;
  assign b_abs  = b_neg ? -Rdata2 : Rdata2;

  logic [WIDTH:0]     sum, shf;
  logic [2*WIDTH-1:0] prod;

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    m_d       = m_q;
    raw_d     = raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    shf       = '0;
    prod      = '0;

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          case (Func)
            F_MTHI: hi_d = Rdata1;
            F_MTLO: lo_d = Rdata1;
            F_MULT, F_MULTU: begin
              state_d   = S_MUL;
              cnt_d     = CW'(WIDTH - 1);
              acc_d     = '0;
              wrk_d     = b_abs;
              m_d       = a_abs;
              is_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              ovf_d     = 1'b0;
            end
            F_DIV, F_DIVU: begin
              state_d   = S_DIV;
              cnt_d     = CW'(WIDTH - 1);
              acc_d     = '0;
              wrk_d     = a_abs;
              m_d       = b_abs;
              raw_d     = Rdata1;
              is_div_d  = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (Rdata2 == '0);
              ovf_d     = op_sgn && (Rdata1 == MOST_NEG) && (Rdata2 == '1);
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        // Add multiplicand if LSB of multiplier set, then shift {acc,wrk} right
        sum   = acc_q + (wrk_q[0] ? {1'b0, m_q} : '0);
        acc_d = {1'b0, sum[WIDTH:1]};
        wrk_d = {sum[0], wrk_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_DIV: begin
        // Shift next dividend bit into remainder; subtract divisor if it fits
        shf = {acc_q[WIDTH-1:0], wrk_q[WIDTH-1]};
        if (shf >= {1'b0, m_q}) begin
          acc_d = shf - {1'b0, m_q};
          wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shf;
          wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          prod = {acc_q[WIDTH-1:0], wrk_q};
          if (neg_res_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = raw_q;
          lo_d = '1;
        end else if (ovf_q) begin
          hi_d = '0;
          lo_d = MOST_NEG;
        end else begin
          hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          lo_d = neg_res_q ? -wrk_q : wrk_q;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including the FIX write
    if (Abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      m_q       <= '0;
      raw_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      m_q       <= m_d;
      raw_q     <= raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_ex_muldiv_unit;

  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] NOP   = 6'h3F;

  logic        CLK = 1'b0;
  logic        RST, Start32, Start8, Abort;
  logic [5:0]  Func;
  logic [31:0] A, B;
  logic        Busy32, Done32, Busy8, Done8;
  logic [31:0] HI32, LO32;
  logic [7:0]  HI8, LO8;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [31:0] m_hi, m_lo;

  always #5 CLK = ~CLK;

  ex_muldiv_unit #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RST(RST), .Start(Start32), .Func(Func), .Rdata1(A), .Rdata2(B),
    .Abort(Abort), .Busy(Busy32), .Done(Done32), .HI(HI32), .LO(LO32)
  );

  ex_muldiv_unit #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .Start(Start8), .Func(Func), .Rdata1(A[7:0]), .Rdata2(B[7:0]),
    .Abort(Abort), .Busy(Busy8), .Done(Done8), .HI(HI8), .LO(LO8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: every Done pops one expected {HI,LO}
  always @(negedge CLK) begin
    if (!RST && Done32) begin
      n_vec++;
      if (q32.size() == 0) begin
        n_bad++;
        $display("FAIL done32_unexpected: got HI=%h LO=%h, expected no Done", HI32, LO32);
      end else begin
        logic [63:0] e;
        e = q32.pop_front();
        if ({HI32, LO32} !== e) begin
          n_bad++;
          $display("FAIL result32: got %h_%h, expected %h_%h", HI32, LO32, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && Done8) begin
      n_vec++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL done8_unexpected: got HI=%h LO=%h, expected no Done", HI8, LO8);
      end else begin
        logic [15:0] e;
        e = q8.pop_front();
        if ({HI8, LO8} !== e) begin
          n_bad++;
          $display("FAIL result8: got %h_%h, expected %h_%h", HI8, LO8, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present one request for a single edge; returns in the cycle after accept
  task automatic drive_start(input bit w8, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if (w8) Start8 = 1'b1; else Start32 = 1'b1;
    Func = f; A = a; B = b;
    wait_cyc(1);
    Start8 = 1'b0; Start32 = 1'b0; Func = NOP;
  endtask

  // Cycles counted from the cycle after accept (=1) until Done is seen
  task automatic wait_done(input bit w8, output int lat, output int bc);
    lat = 1; bc = 0;
    while (!(w8 ? Done8 : Done32) && lat < 60) begin
      if (w8 ? Busy8 : Busy32) bc++;
      wait_cyc(1);
      lat++;
    end
  endtask

  task automatic op(input bit w8, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bc;
    if (w8) q8.push_back({ehi[7:0], elo[7:0]});
    else    q32.push_back({ehi, elo});
    drive_start(w8, f, a, b);
    wait_done(w8, lat, bc);
    chk(w8 ? "latency8" : "latency32", 64'(lat), w8 ? 64'd10 : 64'd34);
    chk(w8 ? "busy_cycles8" : "busy_cycles32", 64'(bc), w8 ? 64'd9 : 64'd33);
    if (!w8) begin m_hi = ehi; m_lo = elo; end
  endtask

  initial begin
    int lat, bc;
    RST = 1'b1; Start32 = 1'b0; Start8 = 1'b0; Abort = 1'b0;
    Func = NOP; A = '0; B = '0; m_hi = '0; m_lo = '0;
    wait_cyc(3);
    RST = 1'b0;
    chk("reset32", {30'd0, Busy32, Done32, HI32, LO32}, 64'd0);
    chk("reset8", {46'd0, Busy8, Done8, HI8, LO8}, 64'd0);

    // 32-bit multiply / divide vectors (back-to-back accepts)
    op(0, MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    op(0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    op(0, MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    op(0, MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    op(0, DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    op(0, DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    op(0, DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    op(0, DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
    op(0, DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    op(0, DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI while busy is dropped
    q32.push_back({32'd2, 32'd14});
    drive_start(0, DIVU, 32'd100, 32'd7);
    wait_cyc(2);
    Start32 = 1'b1; Func = MTHI; A = 32'h1234;
    wait_cyc(1);
    Start32 = 1'b0; Func = NOP;
    wait_done(0, lat, bc);
    chk("busy_mthi_done_seen", {63'd0, Done32}, 64'd1);
    chk("busy_mthi_hi", {32'd0, HI32}, 64'd2);
    m_hi = 32'd2; m_lo = 32'd14;
    wait_cyc(1);

    // MTLO / MTHI while idle
    drive_start(0, MTLO, 32'hABCD, 32'd0);
    chk("mtlo_lo", {32'd0, LO32}, 64'hABCD);
    chk("mtlo_busy_done", {62'd0, Busy32, Done32}, 64'd0);
    m_lo = 32'hABCD;
    drive_start(0, MTHI, 32'h5A5A, 32'd0);
    chk("mthi_hi", {32'd0, HI32}, 64'h5A5A);
    m_hi = 32'h5A5A;

    // Abort together with Start in idle: nothing happens
    Abort = 1'b1;
    drive_start(0, MTHI, 32'h5555, 32'd0);
    Abort = 1'b0;
    chk("abort_idle_hilo", {HI32, LO32}, {m_hi, m_lo});

    // Abort in cycle T+10
    drive_start(0, DIVU, 32'd100, 32'd7);
    wait_cyc(9);
    Abort = 1'b1;
    wait_cyc(1);
    Abort = 1'b0;
    chk("abort_mid_busy", {63'd0, Busy32}, 64'd0);
    wait_cyc(40);
    chk("abort_mid_hilo", {HI32, LO32}, {m_hi, m_lo});

    // Abort in the FIX cycle (T+WIDTH+1)
    drive_start(0, DIVU, 32'd100, 32'd7);
    wait_cyc(32);
    chk("fix_still_busy", {63'd0, Busy32}, 64'd1);
    Abort = 1'b1;
    wait_cyc(1);
    Abort = 1'b0;
    chk("abort_fix_busy_done", {62'd0, Busy32, Done32}, 64'd0);
    chk("abort_fix_hilo", {HI32, LO32}, {m_hi, m_lo});
    wait_cyc(5);

    // Reset mid-multiply, then an immediate new start
    drive_start(0, MULT, 32'd3, 32'd4);
    wait_cyc(5);
    RST = 1'b1;
    wait_cyc(1);
    RST = 1'b0;
    q32.delete();
    chk("rst_mid32", {30'd0, Busy32, Done32, HI32, LO32}, 64'd0);
    op(0, MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // 8-bit corner cases
    op(1, MULT,  32'hFD, 32'h05, 32'hFF, 32'hF1);
    op(1, MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01);
    op(1, MULT,  32'hFF, 32'hFF, 32'h00, 32'h01);
    op(1, DIV,   32'hF9, 32'h02, 32'hFF, 32'hFD);
    op(1, DIVU,  32'h07, 32'h00, 32'h07, 32'hFF);
    op(1, DIV,   32'h80, 32'hFF, 32'h00, 32'h80);
    wait_cyc(3);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
